// File: rtl/startdone_pkg.sv
// Shared types for the start/done sequencer: FSM states, command mode codes, channel picker.
// Pure declarations; no clocked logic and no flow control of its own.
// Timeout feature macro used by the users of this package: STARTDONE_TIMEOUT_EN.
package startdone_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAR_RUN,
        ST_SEQ_RUN,
        ST_FINISH
    } state_e;

    localparam logic MODE_PAR = 1'b0;
    localparam logic MODE_SEQ = 1'b1;

    localparam int MAX_CH = 16;

    // One-hot of the lowest set bit; zero in, zero out.
    function automatic logic [MAX_CH-1:0] lowest_set(input logic [MAX_CH-1:0] v);
        return v & (~v + MAX_CH'(1));
    endfunction

endpackage

// File: rtl/startdone_chan.sv
// One accelerator channel: start level, saturating run-cycle counter, optional timeout (STARTDONE_TIMEOUT_EN).
// Latency: start rises the cycle after launch and falls the cycle after done/timeout is sampled.
// Backpressure: none; done is a level that is honoured only while start is high.
module startdone_chan #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic             clk_clk,
    input  logic             launch,
    input  logic             abort,
    input  logic             done_in,
    output logic             start,
    output logic             complete,
    output logic [CNT_W-1:0] count,
    output logic             timeout_err
);

    logic             start_q, start_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_hit;

`ifdef STARTDONE_TIMEOUT_EN
    logic err_q, err_d;

    // The increment on this cycle lands the count exactly on the limit.
    assign timeout_hit = start_q & ~done_in & (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        err_d = err_q;
        if (timeout_hit) err_d = 1'b1;
        if (launch)      err_d = 1'b0;
        if (abort)       err_d = 1'b0;
    end

    always_ff @(posedge clk_clk) begin
        err_q <= err_d;
    end

    assign timeout_err = err_q;
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = (TIMEOUT_CYC == 0);
    assign timeout_hit        = 1'b0;
    assign timeout_err        = 1'b0;
`endif

    assign complete = start_q & (done_in | timeout_hit);

    always_comb begin
        start_d = start_q;
        cnt_d   = cnt_q;
        if (start_q) begin
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            if (complete)    start_d = 1'b0;
        end
        if (launch) begin
            start_d = 1'b1;
            cnt_d   = '0;
        end
        // abort carries the block reset and wins over everything else
        if (abort) begin
            start_d = 1'b0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk_clk) begin
        start_q <= start_d;
        cnt_q   <= cnt_d;
    end

    assign start = start_q;
    assign count = cnt_q;

endmodule

// File: rtl/startdone_seq.sv
// Start/done sequencer over NUM_CH channels, parallel or ascending sequential launch (timeout: STARTDONE_TIMEOUT_EN).
// Latency: starts high 1 cycle after accept; done_pulse 1 cycle after last completion; ready again 1 cycle later.
// Backpressure: cmd_ready low while busy; commands offered then are dropped, not queued.
module startdone_seq
    import startdone_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [NUM_CH-1:0]       cmd_mask,
    input  logic                    cmd_mode,
    output logic [NUM_CH-1:0]       startsig_export,
    input  logic [NUM_CH-1:0]       donesig_export,
    output logic                    busy,
    output logic                    done_pulse,
    output logic [NUM_CH*CNT_W-1:0] cycles_flat,
    output logic [NUM_CH-1:0]       timeout_err
);

    state_e              state_q, state_d;
    logic [NUM_CH-1:0]   pend_q, pend_d;
    logic [NUM_CH-1:0]   launch, complete, next_ch;
    logic [MAX_CH-1:0]   pick_src, pick_1h;
    logic                accept;

    assign cmd_ready  = reset_reset_n & (state_q == ST_IDLE);
    assign accept     = cmd_valid & cmd_ready;
    assign busy       = (state_q != ST_IDLE);
    assign done_pulse = (state_q == ST_FINISH);

    // In IDLE the candidate set is the incoming mask, afterwards the pending set.
    always_comb begin
        pick_src             = '0;
        pick_src[NUM_CH-1:0] = (state_q == ST_IDLE) ? cmd_mask : pend_q;
        pick_1h              = lowest_set(pick_src);
        next_ch              = pick_1h[NUM_CH-1:0];
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        launch  = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (cmd_mask == '0) begin
                        state_d = ST_FINISH;
                    end else if (cmd_mode == MODE_SEQ) begin
                        launch  = next_ch;
                        pend_d  = cmd_mask & ~next_ch;
                        state_d = ST_SEQ_RUN;
                    end else begin
                        launch  = cmd_mask;
                        pend_d  = cmd_mask;
                        state_d = ST_PAR_RUN;
                    end
                end
            end
            ST_PAR_RUN: begin
                pend_d = pend_q & ~complete;
                if (pend_d == '0) state_d = ST_FINISH;
            end
            ST_SEQ_RUN: begin
                // Only the running channel can complete; pend_q excludes it.
                if (|complete) begin
                    if (pend_q == '0) begin
                        state_d = ST_FINISH;
                    end else begin
                        launch = next_ch;
                        pend_d = pend_q & ~next_ch;
                    end
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        startdone_chan #(
            .CNT_W       (CNT_W),
            .TIMEOUT_CYC (TIMEOUT_CYC)
        ) u_chan (
            .clk_clk     (clk_clk),
            .launch      (launch[i]),
            .abort       (~reset_reset_n),
            .done_in     (donesig_export[i]),
            .start       (startsig_export[i]),
            .complete    (complete[i]),
            .count       (cycles_flat[i*CNT_W +: CNT_W]),
            .timeout_err (timeout_err[i])
        );
    end

endmodule
